// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the fetch sequencer: default widths, FSM encodings, redirect decode.
package fetch_sequencer_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int INSTR_W_DEF    = 32;
    localparam int STEP_DEF       = 4;
    localparam int LOOP_CNT_W_DEF = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    function automatic logic is_redirect(input logic jump, input logic branch, input logic zero);
        return jump | (branch & zero);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request channel and decode-side instruction channel.
interface fetch_sequencer_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) ();
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ready, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ready, imem_rdata, instr_ready
    );
endinterface

// File: rtl/fetch_sequencer_hw_loop_unit.sv
// Hardware-loop (vector repeat) state: body bounds, remaining loop-backs, loop-back decision.
// Latency: loop-back hit is combinational on the current pc; counter updates next cycle.
// Backpressure: only advances on an accepted fetch that is not overridden by a redirect.
module hw_loop_unit #(
    parameter int ADDR_W     = 32,
    parameter int LOOP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  loop_set,
    input  logic [ADDR_W-1:0]     loop_start,
    input  logic [ADDR_W-1:0]     loop_end,
    input  logic [LOOP_CNT_W-1:0] loop_count,
    input  logic                  advance,
    input  logic [ADDR_W-1:0]     pc,
    output logic                  loop_hit,
    output logic [ADDR_W-1:0]     loop_target,
    output logic                  loop_active
);
    logic [ADDR_W-1:0]     start_q;
    logic [ADDR_W-1:0]     end_q;
    logic [LOOP_CNT_W-1:0] cnt_q;

    assign loop_active = (cnt_q != '0);
    assign loop_hit    = advance && loop_active && (pc == end_q);
    assign loop_target = start_q;

    // A new loop_set replaces any loop in progress, including one hitting this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_q <= '0;
            end_q   <= '0;
            cnt_q   <= '0;
        end else if (loop_set) begin
            start_q <= loop_start;
            end_q   <= loop_end;
            cnt_q   <= loop_count;
        end else if (loop_hit) begin
            cnt_q <= cnt_q - LOOP_CNT_W'(1);
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner: issues imem reads and holds one fetched word for decode.
// Latency: read data appears on instr one cycle after imem_req&imem_ready; 1 instr/cycle sustained.
// Backpressure: a stalled decode holds the buffer and suppresses imem_req; redirects flush it.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                INSTR_W    = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                STEP       = STEP_DEF,
    parameter int                LOOP_CNT_W = LOOP_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  halt,
    input  logic                  branch,
    input  logic                  zero,
    input  logic                  jump,
    input  logic [ADDR_W-1:0]     target_addr,
    input  logic                  loop_set,
    input  logic [ADDR_W-1:0]     loop_start,
    input  logic [ADDR_W-1:0]     loop_end,
    input  logic [LOOP_CNT_W-1:0] loop_count,
    fetch_sequencer_if.master     bus,
    output logic [ADDR_W-1:0]     pc,
    output logic                  loop_active
);
    logic [1:0]         state;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  next_pc;
    logic               instr_valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  instr_pc_q;
    logic               redirect;
    logic               req;
    logic               xfer;
    logic               consume;
    logic               loop_hit;
    logic [ADDR_W-1:0]  loop_target;

    assign redirect = is_redirect(jump, branch, zero);
    assign req      = (state == ST_RUN) && (!instr_valid_q || bus.instr_ready);
    assign xfer     = req && bus.imem_ready;
    assign consume  = instr_valid_q && bus.instr_ready;

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign pc              = pc_q;

    hw_loop_unit #(
        .ADDR_W     (ADDR_W),
        .LOOP_CNT_W (LOOP_CNT_W)
    ) u_loop (
        .clk         (clk),
        .reset       (reset),
        .loop_set    (loop_set),
        .loop_start  (loop_start),
        .loop_end    (loop_end),
        .loop_count  (loop_count),
        .advance     (xfer && !redirect),
        .pc          (pc_q),
        .loop_hit    (loop_hit),
        .loop_target (loop_target),
        .loop_active (loop_active)
    );

    always_comb begin
        next_pc = pc_q;
        if (redirect) begin
            next_pc = target_addr;
        end else if (xfer) begin
            next_pc = loop_hit ? loop_target : pc_q + ADDR_W'(STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   state <= ST_RUN;
                ST_RUN:    state <= halt ? ST_HALTED : ST_RUN;
                ST_HALTED: state <= halt ? ST_HALTED : ST_RUN;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // A redirect drops both the held word and any word arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            pc_q <= next_pc;
            if (redirect) begin
                instr_valid_q <= 1'b0;
            end else if (xfer) begin
                instr_valid_q <= 1'b1;
                instr_q       <= bus.imem_rdata;
                instr_pc_q    <= pc_q;
            end else if (consume) begin
                instr_valid_q <= 1'b0;
            end
        end
    end
endmodule
